pipe_hazard_ctrl: RTL and testbench
===================================

// Module: pipe_hazard_ctrl
// PURPOSE
//  Hazard/sequencing controller for the 5-stage RV32 pipeline fed by the instruction decoder.
//  Generates operand-forwarding selects, load-use stalls, branch/jump flushes and a multi-cycle
//  MUL hold FSM. Sits beside the pipeline registers and drives their stall/flush enables.
// PARAMETERS
//  MUL_CYCLES  4   EX-stage cycles a MUL occupies (>=1); 1 = single-cycle, no hold
//  REG_AW      5   register-index width
// PORTS
//  clk          in   1       rising-edge clock
//  rst          in   1       asynchronous, active-high reset
//  id_valid     in   1       ID stage holds a real instruction
//  id_rs1       in   REG_AW  ID source reg 1
//  id_rs2       in   REG_AW  ID source reg 2
//  ex_rs1       in   REG_AW  EX source reg 1
//  ex_rs2       in   REG_AW  EX source reg 2
//  ex_rd        in   REG_AW  EX destination
//  ex_is_load   in   1       EX instr is a load (ResultSrc==2'b01 with RegWrite)
//  ex_mul_start in   1       EX instr is MUL (alu_control==4'b0110), first EX cycle
//  ex_redirect  in   1       branch taken or jump resolved in EX
//  mem_rd       in   REG_AW  MEM destination;  mem_regwrite in 1  MEM writes rd
//  wb_rd        in   REG_AW  WB destination;   wb_regwrite  in 1  WB writes rd
//  fwd_a        out  2       EX operand A select: 00 regfile, 01 WB result, 10 MEM ALU result
//  fwd_b        out  2       EX operand B select, same encoding
//  stall_f      out  1       hold PC
//  stall_d      out  1       hold IF/ID register
//  stall_e      out  1       hold ID/EX register
//  flush_d      out  1       clear IF/ID to bubble
//  flush_e      out  1       clear ID/EX to bubble
//  mul_busy     out  1       MUL hold in progress
//  mul_done     out  1       1-cycle pulse: MUL result valid in EX this cycle
// BEHAVIOUR
//  Reset: state=RUN, mul_cnt=0; while rst=1 every output is 0.
//  Forwarding (combinational, both ports): MEM wins over WB. fwd_a=10 if mem_regwrite &
//   mem_rd!=0 & mem_rd==ex_rs1; else 01 if wb_regwrite & wb_rd!=0 & wb_rd==ex_rs1; else 00.
//   x0 is never forwarded.
//  Load-use (combinational, RUN only): lu = id_valid & ex_is_load & ex_rd!=0 &
//   (ex_rd==id_rs1 | ex_rd==id_rs2). lu -> stall_f=stall_d=1, flush_e=1 for exactly that
//   cycle; the next cycle the load is in MEM and forwarding resolves it.
//  Redirect (RUN only): ex_redirect -> flush_d=flush_e=1, stall_f=stall_d=0. Redirect
//   overrides lu in the same cycle (squashed instr needs no stall).
//  FSM RUN/MUL_WAIT:
//   RUN: ex_mul_start & MUL_CYCLES>1 -> MUL_WAIT, mul_cnt<=MUL_CYCLES-2, stall_f/d/e=1 that
//    cycle. MUL_CYCLES==1 -> stay RUN, mul_done=1 same cycle.
//   MUL_WAIT: stall_f=stall_d=stall_e=1, mul_busy=1, flushes 0, lu ignored, ex_redirect
//    ignored (EX is held, so it is re-presented after exit). mul_cnt==0 -> RUN with
//    mul_done=1 this cycle and stalls released; else mul_cnt--.
//   mul_busy=1 also on the RUN->MUL_WAIT entry cycle. ex_mul_start is ignored in MUL_WAIT.
//  Latency: MUL holds the pipe MUL_CYCLES-1 cycles; load-use costs 1 bubble; redirect 2.
//  rst mid-MUL: immediate return to RUN, all outputs 0, no mul_done.
// CONFIGURATION
//  HAZ_PERF_CNT_EN defined: adds outputs perf_stall_cyc[31:0] (cycles with stall_f=1) and
//   perf_flush_cnt[31:0] (cycles with flush_d|flush_e); both reset to 0 and wrap at 2^32.
//  Undefined: ports and counters absent; all other behaviour identical.
// TESTING
//  ex_rs1=5, mem_rd=5/mem_regwrite=1, wb_rd=5/wb_regwrite=1 -> fwd_a=10; mem_rd=0 -> fwd_a=01
//  ex_is_load=1, ex_rd=7, id_rs2=7, id_valid=1 -> stall_f=stall_d=flush_e=1 for 1 cycle only
//  same as above plus ex_redirect=1 -> flush_d=flush_e=1, stall_f=stall_d=0
//  MUL_CYCLES=4, ex_mul_start pulse -> stall_f/d/e=1 for 3 cycles, mul_done on 4th, then 0
//  rst asserted during MUL_WAIT -> next edge all outputs 0, state RUN, no mul_done pulse
//  HAZ_PERF_CNT_EN: run two load-use stalls + one redirect -> perf_stall_cyc=2, perf_flush_cnt=3

Source files
------------

// File: rtl/pipe_hazard_ctrl.sv
// Hazard/sequencing controller for the 5-stage RV32 pipeline: forwarding selects, load-use stalls,
// redirect flushes and a multi-cycle MUL hold. Optional perf counters via HAZ_PERF_CNT_EN.
module pipe_hazard_ctrl #(
    parameter int MUL_CYCLES = 4,
    parameter int REG_AW     = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              id_valid,
    input  logic [REG_AW-1:0] id_rs1,
    input  logic [REG_AW-1:0] id_rs2,
    input  logic [REG_AW-1:0] ex_rs1,
    input  logic [REG_AW-1:0] ex_rs2,
    input  logic [REG_AW-1:0] ex_rd,
    input  logic              ex_is_load,
    input  logic              ex_mul_start,
    input  logic              ex_redirect,
    input  logic [REG_AW-1:0] mem_rd,
    input  logic              mem_regwrite,
    input  logic [REG_AW-1:0] wb_rd,
    input  logic              wb_regwrite,
    output logic [1:0]        fwd_a,
    output logic [1:0]        fwd_b,
    output logic              stall_f,
    output logic              stall_d,
    output logic              stall_e,
    output logic              flush_d,
    output logic              flush_e,
    output logic              mul_busy,
    output logic              mul_done
`ifdef HAZ_PERF_CNT_EN
    ,
    output logic [31:0]       perf_stall_cyc,
    output logic [31:0]       perf_flush_cnt
`endif
);

    localparam int CNT_W = (MUL_CYCLES > 2) ? $clog2(MUL_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'((MUL_CYCLES > 1) ? MUL_CYCLES - 2 : 0);

    typedef enum logic {
        RUN,
        MUL_WAIT
    } state_t;

    state_t           state, state_n;
    logic [CNT_W-1:0] mul_cnt, mul_cnt_n;
    logic             load_use;

    // MEM result is younger than WB, so it wins; x0 is hardwired zero and never forwarded.
    function automatic logic [1:0] fwd_sel(
        input logic [REG_AW-1:0] rs,
        input logic [REG_AW-1:0] m_rd,
        input logic              m_we,
        input logic [REG_AW-1:0] w_rd,
        input logic              w_we
    );
        if (m_we && (m_rd != '0) && (m_rd == rs))
            return 2'b10;
        else if (w_we && (w_rd != '0) && (w_rd == rs))
            return 2'b01;
        else
            return 2'b00;
    endfunction

    assign load_use = id_valid && ex_is_load && (ex_rd != '0) &&
                      ((ex_rd == id_rs1) || (ex_rd == id_rs2));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= RUN;
            mul_cnt <= '0;
        end else begin
            state   <= state_n;
            mul_cnt <= mul_cnt_n;
        end
    end

    always_comb begin
        state_n   = state;
        mul_cnt_n = mul_cnt;
        fwd_a     = 2'b00;
        fwd_b     = 2'b00;
        stall_f   = 1'b0;
        stall_d   = 1'b0;
        stall_e   = 1'b0;
        flush_d   = 1'b0;
        flush_e   = 1'b0;
        mul_busy  = 1'b0;
        mul_done  = 1'b0;
        if (!rst) begin
            fwd_a = fwd_sel(ex_rs1, mem_rd, mem_regwrite, wb_rd, wb_regwrite);
            fwd_b = fwd_sel(ex_rs2, mem_rd, mem_regwrite, wb_rd, wb_regwrite);
            case (state)
                RUN: begin
                    if (ex_mul_start) begin
                        if (MUL_CYCLES > 1) begin
                            state_n   = MUL_WAIT;
                            mul_cnt_n = CNT_LOAD;
                            stall_f   = 1'b1;
                            stall_d   = 1'b1;
                            stall_e   = 1'b1;
                            mul_busy  = 1'b1;
                        end else begin
                            mul_done  = 1'b1;
                        end
                    end else if (ex_redirect) begin
                        // The instruction behind the redirect is squashed, so it never needs a stall.
                        flush_d = 1'b1;
                        flush_e = 1'b1;
                    end else if (load_use) begin
                        stall_f = 1'b1;
                        stall_d = 1'b1;
                        flush_e = 1'b1;
                    end
                end
                MUL_WAIT: begin
                    if (mul_cnt == '0) begin
                        state_n  = RUN;
                        mul_done = 1'b1;
                    end else begin
                        mul_cnt_n = mul_cnt - 1'b1;
                        stall_f   = 1'b1;
                        stall_d   = 1'b1;
                        stall_e   = 1'b1;
                        mul_busy  = 1'b1;
                    end
                end
                default: state_n = RUN;
            endcase
        end
    end

`ifdef HAZ_PERF_CNT_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            perf_stall_cyc <= '0;
            perf_flush_cnt <= '0;
        end else begin
            if (stall_f)
                perf_stall_cyc <= perf_stall_cyc + 32'd1;
            if (flush_d || flush_e)
                perf_flush_cnt <= perf_flush_cnt + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Scoreboard bench for pipe_hazard_ctrl: directed cases then random traffic against a cycle-age
// reference model. Perf counters are checked when HAZ_PERF_CNT_EN is defined.
module tb_pipe_hazard_ctrl;

    localparam int MUL_CYCLES = 4;
    localparam int REG_AW     = 5;

    typedef struct packed {
        logic              rst;
        logic              id_valid;
        logic [REG_AW-1:0] id_rs1;
        logic [REG_AW-1:0] id_rs2;
        logic [REG_AW-1:0] ex_rs1;
        logic [REG_AW-1:0] ex_rs2;
        logic [REG_AW-1:0] ex_rd;
        logic              ex_is_load;
        logic              ex_mul_start;
        logic              ex_redirect;
        logic [REG_AW-1:0] mem_rd;
        logic              mem_regwrite;
        logic [REG_AW-1:0] wb_rd;
        logic              wb_regwrite;
    } stim_t;

    typedef struct packed {
        logic [1:0] fwd_a;
        logic [1:0] fwd_b;
        logic       stall_f;
        logic       stall_d;
        logic       stall_e;
        logic       flush_d;
        logic       flush_e;
        logic       mul_busy;
        logic       mul_done;
    } exp_t;

    logic              clk;
    logic              rst;
    logic              id_valid;
    logic [REG_AW-1:0] id_rs1, id_rs2, ex_rs1, ex_rs2, ex_rd, mem_rd, wb_rd;
    logic              ex_is_load, ex_mul_start, ex_redirect, mem_regwrite, wb_regwrite;
    logic [1:0]        fwd_a, fwd_b;
    logic              stall_f, stall_d, stall_e, flush_d, flush_e, mul_busy, mul_done;
`ifdef HAZ_PERF_CNT_EN
    logic [31:0]       perf_stall_cyc, perf_flush_cnt;
`endif

    pipe_hazard_ctrl #(.MUL_CYCLES(MUL_CYCLES), .REG_AW(REG_AW)) dut (
        .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
        .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_rd(ex_rd), .ex_is_load(ex_is_load),
        .ex_mul_start(ex_mul_start), .ex_redirect(ex_redirect), .mem_rd(mem_rd),
        .mem_regwrite(mem_regwrite), .wb_rd(wb_rd), .wb_regwrite(wb_regwrite),
        .fwd_a(fwd_a), .fwd_b(fwd_b), .stall_f(stall_f), .stall_d(stall_d), .stall_e(stall_e),
        .flush_d(flush_d), .flush_e(flush_e), .mul_busy(mul_busy), .mul_done(mul_done)
`ifdef HAZ_PERF_CNT_EN
        , .perf_stall_cyc(perf_stall_cyc), .perf_flush_cnt(perf_flush_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    exp_t        exp_q[$];
    int          tests_run = 0;
    int          tests_failed = 0;
    bit          stim_done = 1'b0;
    bit          m_in_mul = 1'b0;
    int          m_age = 0;
    logic [31:0] m_stall_cnt = '0;
    logic [31:0] m_flush_cnt = '0;

    function automatic logic [1:0] ref_fwd(input stim_t s, input logic [REG_AW-1:0] rs);
        if (rs == 0) return 2'b00;
        if (s.mem_regwrite && s.mem_rd == rs) return 2'b10;
        if (s.wb_regwrite && s.wb_rd == rs) return 2'b01;
        return 2'b00;
    endfunction

    // A MUL occupies EX for MUL_CYCLES cycles counted from its start; all but the last are stalls.
    task automatic refModel(input stim_t s, output exp_t e);
        bit lu;
        e = '0;
        if (s.rst) begin
            m_in_mul    = 1'b0;
            m_stall_cnt = '0;
            m_flush_cnt = '0;
            return;
        end
        e.fwd_a = ref_fwd(s, s.ex_rs1);
        e.fwd_b = ref_fwd(s, s.ex_rs2);
        if (!m_in_mul && s.ex_mul_start) begin
            m_in_mul = 1'b1;
            m_age    = 0;
        end
        if (m_in_mul) begin
            if (m_age == MUL_CYCLES - 1) begin
                e.mul_done = 1'b1;
                m_in_mul   = 1'b0;
            end else begin
                {e.stall_f, e.stall_d, e.stall_e, e.mul_busy} = 4'b1111;
                m_age++;
            end
        end else begin
            lu = s.id_valid && s.ex_is_load && s.ex_rd != 0 &&
                 (s.ex_rd == s.id_rs1 || s.ex_rd == s.id_rs2);
            if (s.ex_redirect)
                {e.flush_d, e.flush_e} = 2'b11;
            else if (lu)
                {e.stall_f, e.stall_d, e.flush_e} = 3'b111;
        end
        if (e.stall_f) m_stall_cnt++;
        if (e.flush_d || e.flush_e) m_flush_cnt++;
    endtask

    task automatic applyStimulus(input stim_t s);
        exp_t e;
        @(posedge clk);
        #1;
        rst = s.rst; id_valid = s.id_valid; id_rs1 = s.id_rs1; id_rs2 = s.id_rs2;
        ex_rs1 = s.ex_rs1; ex_rs2 = s.ex_rs2; ex_rd = s.ex_rd; ex_is_load = s.ex_is_load;
        ex_mul_start = s.ex_mul_start; ex_redirect = s.ex_redirect; mem_rd = s.mem_rd;
        mem_regwrite = s.mem_regwrite; wb_rd = s.wb_rd; wb_regwrite = s.wb_regwrite;
        refModel(s, e);
        exp_q.push_back(e);
    endtask

    task automatic checkOutput(input string name, input logic [3:0] act, input logic [3:0] req);
        tests_run++;
        if (act !== req) begin
            tests_failed++;
            $display("[TB] FAIL %s at %0t: got %b, expected %b", name, $time, act, req);
        end
    endtask

    function automatic stim_t randStim();
        stim_t s;
        s.rst          = ($urandom_range(0, 59) == 0);
        s.id_valid     = ($urandom_range(0, 3) != 0);
        s.id_rs1       = REG_AW'($urandom_range(0, 3));
        s.id_rs2       = REG_AW'($urandom_range(0, 3));
        s.ex_rs1       = REG_AW'($urandom_range(0, 3));
        s.ex_rs2       = REG_AW'($urandom_range(0, 3));
        s.ex_rd        = REG_AW'($urandom_range(0, 3));
        s.ex_is_load   = ($urandom_range(0, 2) == 0);
        s.ex_redirect  = ($urandom_range(0, 7) == 0);
        s.ex_mul_start = ($urandom_range(0, 7) == 0);
        s.mem_rd       = REG_AW'($urandom_range(0, 3));
        s.mem_regwrite = ($urandom_range(0, 1) == 0);
        s.wb_rd        = REG_AW'($urandom_range(0, 3));
        s.wb_regwrite  = ($urandom_range(0, 1) == 0);
        // One EX instruction cannot be a MUL and also a load or a branch.
        if (s.ex_mul_start) begin
            s.ex_is_load  = 1'b0;
            s.ex_redirect = 1'b0;
        end
        return s;
    endfunction

    // Monitor: one expected response per cycle, compared mid-cycle.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                checkOutput("fwd", {fwd_a, fwd_b}, {e.fwd_a, e.fwd_b});
                checkOutput("stall", {1'b0, stall_f, stall_d, stall_e}, {1'b0, e.stall_f, e.stall_d, e.stall_e});
                checkOutput("flush", {2'b00, flush_d, flush_e}, {2'b00, e.flush_d, e.flush_e});
                checkOutput("mul", {2'b00, mul_busy, mul_done}, {2'b00, e.mul_busy, e.mul_done});
            end
        end
    end

    initial begin
        stim_t s, idle;
        int    wait_cyc;
        rst = 1'b1; id_valid = 1'b0; id_rs1 = '0; id_rs2 = '0; ex_rs1 = '0; ex_rs2 = '0;
        ex_rd = '0; ex_is_load = 1'b0; ex_mul_start = 1'b0; ex_redirect = 1'b0;
        mem_rd = '0; mem_regwrite = 1'b0; wb_rd = '0; wb_regwrite = 1'b0;
        idle = '0;

        // Reset with forwarding-hit inputs present: every output must stay 0.
        s = idle; s.rst = 1'b1; s.ex_rs1 = 5; s.mem_rd = 5; s.mem_regwrite = 1'b1;
        applyStimulus(s);
        applyStimulus(s);

        s = idle; s.ex_rs1 = 5; s.ex_rs2 = 5; s.mem_rd = 5; s.mem_regwrite = 1'b1;
        s.wb_rd = 5; s.wb_regwrite = 1'b1;
        applyStimulus(s);
        s.mem_rd = 0;
        applyStimulus(s);
        s.ex_rs1 = 0; s.wb_rd = 0;
        applyStimulus(s);

        s = idle; s.ex_is_load = 1'b1; s.ex_rd = 7; s.id_rs2 = 7; s.id_valid = 1'b1;
        applyStimulus(s);
        applyStimulus(idle);
        s.ex_redirect = 1'b1;
        applyStimulus(s);
        s = idle; s.ex_is_load = 1'b1; s.id_valid = 1'b1;
        applyStimulus(s);

        s = idle; s.ex_mul_start = 1'b1;
        applyStimulus(s);
        for (int i = 0; i < 4; i++) applyStimulus(idle);

        // Redirect and load-use arriving during the hold are ignored.
        applyStimulus(s);
        s = idle; s.ex_redirect = 1'b1; s.ex_mul_start = 1'b1;
        applyStimulus(s);
        s = idle; s.ex_is_load = 1'b1; s.ex_rd = 3; s.id_rs1 = 3; s.id_valid = 1'b1;
        applyStimulus(s);
        applyStimulus(idle);
        applyStimulus(idle);

        // Reset in the middle of a MUL hold, then no mul_done afterwards.
        s = idle; s.ex_mul_start = 1'b1;
        applyStimulus(s);
        applyStimulus(idle);
        s = idle; s.rst = 1'b1;
        applyStimulus(s);
        for (int i = 0; i < 4; i++) applyStimulus(idle);

        for (int i = 0; i < 500; i++) applyStimulus(randStim());

`ifdef HAZ_PERF_CNT_EN
        s = idle; s.rst = 1'b1;
        applyStimulus(s);
        s = idle; s.ex_is_load = 1'b1; s.ex_rd = 7; s.id_rs2 = 7; s.id_valid = 1'b1;
        applyStimulus(s);
        applyStimulus(s);
        s.ex_redirect = 1'b1;
        applyStimulus(s);
        applyStimulus(idle);
`endif
        stim_done = 1'b1;

        wait_cyc = 0;
        while (exp_q.size() > 0 && wait_cyc < 10) begin
            @(posedge clk);
            wait_cyc++;
        end
        tests_run++;
        if (exp_q.size() > 0) begin
            tests_failed++;
            $display("[TB] FAIL drain: %0d responses unchecked, expected 0", exp_q.size());
        end

`ifdef HAZ_PERF_CNT_EN
        tests_run++;
        if (perf_stall_cyc !== m_stall_cnt || m_stall_cnt != 32'd2) begin
            tests_failed++;
            $display("[TB] FAIL perf_stall_cyc: got %0d, expected %0d", perf_stall_cyc, 2);
        end
        tests_run++;
        if (perf_flush_cnt !== m_flush_cnt || m_flush_cnt != 32'd3) begin
            tests_failed++;
            $display("[TB] FAIL perf_flush_cnt: got %0d, expected %0d", perf_flush_cnt, 3);
        end
`endif

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
